// File: rtl/sc_regbus_load_shift_pkg.sv
// Shared definitions for the load/shift general register: FSM encoding and
// shift-direction constants.
package sc_regbus_load_shift_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'b00,
        STATE_SHIFT = 2'b01,
        STATE_DONE  = 2'b10
    } state_t;

    localparam logic SHIFT_DIR_RIGHT = 1'b0;
    localparam logic SHIFT_DIR_LEFT  = 1'b1;

endpackage

// File: rtl/sc_regbus_shift1.sv
// Combinational single-step shifter: left, logical right or arithmetic right.
module sc_regbus_shift1
    import sc_regbus_load_shift_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32
) (
    input  logic [DATAWIDTH_BUS-1:0] shift1Data,
    input  logic                     shift1Dir,
    input  logic                     shift1Arith,
    output logic [DATAWIDTH_BUS-1:0] shift1Result
);

    logic fillBit;

    // Arithmetic right replicates the sign bit; logical right fills with zero.
    assign fillBit = shift1Arith & shift1Data[DATAWIDTH_BUS-1];

    assign shift1Result = (shift1Dir == SHIFT_DIR_LEFT)
                        ? {shift1Data[DATAWIDTH_BUS-2:0], 1'b0}
                        : {fillBit, shift1Data[DATAWIDTH_BUS-1:1]};

endmodule

// File: rtl/sc_regbus_load_shift.sv
// Bus-side general register with load, clear and a multi-cycle serial shift
// under a start/busy/done handshake; all state moves on the falling clock edge.
module sc_regbus_load_shift
    import sc_regbus_load_shift_pkg::*;
#(
    parameter int                     DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REG_INIT = 32'h00000000,
    parameter int                     SHAMT_WIDTH   = 5
) (
    input  logic                     SC_RegLOADSHIFT_CLOCK_50,
    input  logic                     SC_RegGENERAL_RESET_InHigh,
    input  logic                     SC_RegLOADSHIFT_Load_InHigh,
    input  logic                     SC_RegLOADSHIFT_Clear_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegLOADSHIFT_DataBUS_In,
    input  logic                     SC_RegLOADSHIFT_ShiftStart_InHigh,
    input  logic                     SC_RegLOADSHIFT_ShiftLeft_InHigh,
    input  logic                     SC_RegLOADSHIFT_ShiftArith_InHigh,
    input  logic [SHAMT_WIDTH-1:0]   SC_RegLOADSHIFT_ShiftAmount_In,
    output logic [DATAWIDTH_BUS-1:0] SC_RegLOADSHIFT_DataBUS_Out,
    output logic                     SC_RegLOADSHIFT_Busy_Out,
    output logic                     SC_RegLOADSHIFT_Done_Out,
    output logic                     SC_RegLOADSHIFT_Zero_Out
);

    state_t                   stateReg,  stateNext;
    logic [DATAWIDTH_BUS-1:0] dataReg,   dataNext;
    logic [SHAMT_WIDTH-1:0]   countReg,  countNext;
    logic                     dirReg,    dirNext;
    logic                     arithReg,  arithNext;
    logic [DATAWIDTH_BUS-1:0] shiftedData;

    sc_regbus_shift1 #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS)
    ) u_shift1 (
        .shift1Data   (dataReg),
        .shift1Dir    (dirReg),
        .shift1Arith  (arithReg),
        .shift1Result (shiftedData)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(negedge SC_RegLOADSHIFT_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            stateReg <= STATE_IDLE;
            dataReg  <= DATA_REG_INIT;
            countReg <= '0;
            dirReg   <= 1'b0;
            arithReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            dataReg  <= dataNext;
            countReg <= countNext;
            dirReg   <= dirNext;
            arithReg <= arithNext;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        stateNext = stateReg;
        dataNext  = dataReg;
        countNext = countReg;
        dirNext   = dirReg;
        arithNext = arithReg;

        unique case (stateReg)
            STATE_IDLE: begin
                if (SC_RegLOADSHIFT_Clear_InHigh) begin
                    dataNext = '0;
                end else if (SC_RegLOADSHIFT_Load_InHigh) begin
                    dataNext = SC_RegLOADSHIFT_DataBUS_In;
                end else if (SC_RegLOADSHIFT_ShiftStart_InHigh) begin
                    if (SC_RegLOADSHIFT_ShiftAmount_In == '0) begin
                        stateNext = STATE_DONE;
                    end else begin
                        countNext = SC_RegLOADSHIFT_ShiftAmount_In;
                        dirNext   = SC_RegLOADSHIFT_ShiftLeft_InHigh;
                        arithNext = SC_RegLOADSHIFT_ShiftArith_InHigh;
                        stateNext = STATE_SHIFT;
                    end
                end
            end
            STATE_SHIFT: begin
                dataNext  = shiftedData;
                countNext = countReg - SHAMT_WIDTH'(1);
                if (countReg == SHAMT_WIDTH'(1)) begin
                    stateNext = STATE_DONE;
                end
            end
            STATE_DONE: begin
                stateNext = STATE_IDLE;
            end
            default: begin
                stateNext = STATE_IDLE;
            end
        endcase
    end

    assign SC_RegLOADSHIFT_DataBUS_Out = dataReg;
    assign SC_RegLOADSHIFT_Busy_Out    = (stateReg != STATE_IDLE);
    assign SC_RegLOADSHIFT_Done_Out    = (stateReg == STATE_DONE);
    assign SC_RegLOADSHIFT_Zero_Out    = (dataReg == '0);

endmodule
